// File: rtl/hms_timer_pkg.sv
// Shared types and field constants for the h:m:s.ms timer array.
// Time word layout is {hr, min[5:0], sec[5:0], ms[9:0]}, MSB first.
package hms_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } ch_state_e;

  localparam int MS_W        = 10;
  localparam int SEC_W       = 6;
  localparam int MIN_W       = 6;
  localparam int MS_MAX      = 999;
  localparam int SEC_MIN_MAX = 59;

  function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v);
    return (v > MS_W'(MS_MAX)) ? MS_W'(MS_MAX) : v;
  endfunction

  function automatic logic [SEC_W-1:0] clamp_60(input logic [SEC_W-1:0] v);
    return (v > SEC_W'(SEC_MIN_MAX)) ? SEC_W'(SEC_MIN_MAX) : v;
  endfunction

endpackage

// File: rtl/hms_timer_array_if.sv
// Load/run-control and status bundle between a controller and hms_timer_array.
interface hms_timer_array_if
  import hms_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int HR_W   = 5
);
  localparam int T_W = HR_W + MIN_W + SEC_W + MS_W;

  logic                  load_valid;
  logic [2:0]            load_ch;
  logic [T_W-1:0]        load_time;
  logic                  load_up;
  logic [NUM_CH-1:0]     start;
  logic [NUM_CH-1:0]     stop;
  logic [NUM_CH*T_W-1:0] time_o;
  logic [NUM_CH-1:0]     running_o;
  logic [NUM_CH-1:0]     done_o;
  logic [NUM_CH-1:0]     expired_o;

  modport master (
    output load_valid, load_ch, load_time, load_up, start, stop,
    input  time_o, running_o, done_o, expired_o
  );

  modport slave (
    input  load_valid, load_ch, load_time, load_up, start, stop,
    output time_o, running_o, done_o, expired_o
  );
endinterface

// File: rtl/hms_timer_channel.sv
// One timer channel: state, time, mode; 1-cycle update per tick, no backpressure.
// HMS_TIMER_AUTO_RELOAD_EN: down-count reaching zero reloads the last load and keeps running.
module hms_timer_channel
  import hms_timer_pkg::*;
#(
  parameter int HR_W = 5,
  localparam int T_W = HR_W + MIN_W + SEC_W + MS_W
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           tick,
  input  logic           load,
  input  logic [T_W-1:0] load_time,
  input  logic           load_up,
  input  logic           start,
  input  logic           stop,
  output logic [T_W-1:0] time_o,
  output logic           running_o,
  output logic           done_o,
  output logic           expired_o
);

  localparam logic [T_W-1:0] TERM_UP = {{HR_W{1'b1}}, 6'd59, 6'd59, 10'd999};

  ch_state_e      state_q, state_d;
  logic [T_W-1:0] time_q, time_d;
  logic           up_q, up_d;
  logic           expired_q, expired_d;
  logic [T_W-1:0] ld_t, step_t;
`ifdef HMS_TIMER_AUTO_RELOAD_EN
  logic [T_W-1:0] reload_q, reload_d;
`endif

  function automatic logic is_term(input logic up, input logic [T_W-1:0] t);
    return up ? (t == TERM_UP) : (t == '0);
  endfunction

  assign ld_t = {load_time[T_W-1:22], clamp_60(load_time[21:16]),
                 clamp_60(load_time[15:10]), clamp_ms(load_time[9:0])};

  // One-millisecond step with carry/borrow rippling through every field.
  always_comb begin
    logic [HR_W-1:0] hr;
    logic [5:0]      mn, sc;
    logic [9:0]      ms;
    {hr, mn, sc, ms} = time_q;
    if (up_q) begin
      if (ms != 10'(MS_MAX)) ms = ms + 10'd1;
      else begin
        ms = '0;
        if (sc != 6'(SEC_MIN_MAX)) sc = sc + 6'd1;
        else begin
          sc = '0;
          if (mn != 6'(SEC_MIN_MAX)) mn = mn + 6'd1;
          else begin
            mn = '0;
            hr = hr + 1'b1;
          end
        end
      end
    end else begin
      if (ms != '0) ms = ms - 10'd1;
      else begin
        ms = 10'(MS_MAX);
        if (sc != '0) sc = sc - 6'd1;
        else begin
          sc = 6'(SEC_MIN_MAX);
          if (mn != '0) mn = mn - 6'd1;
          else begin
            mn = 6'(SEC_MIN_MAX);
            hr = hr - 1'b1;
          end
        end
      end
    end
    step_t = {hr, mn, sc, ms};
  end

  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    up_d      = up_q;
    expired_d = 1'b0;
`ifdef HMS_TIMER_AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (load) begin
      state_d = ST_IDLE;
      time_d  = ld_t;
      up_d    = load_up;
`ifdef HMS_TIMER_AUTO_RELOAD_EN
      reload_d = ld_t;
`endif
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start && state_q != ST_RUN) begin
      // Starting on a terminal value finishes at once; DONE never re-pulses.
      if (!is_term(up_q, time_q)) state_d = ST_RUN;
      else if (state_q != ST_DONE) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end
    end else if (state_q == ST_RUN && tick) begin
      time_d = step_t;
      if (is_term(up_q, step_t)) begin
        expired_d = 1'b1;
`ifdef HMS_TIMER_AUTO_RELOAD_EN
        if (!up_q) time_d = reload_q;
        else state_d = ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      up_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      up_q      <= up_d;
      expired_q <= expired_d;
    end
  end

`ifdef HMS_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) reload_q <= '0;
    else          reload_q <= reload_d;
  end
`endif

  assign time_o    = time_q;
  assign running_o = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);
  assign expired_o = expired_q;

endmodule

// File: rtl/hms_timer_array.sv
// NUM_CH h:m:s.ms timers sharing one ms prescaler; outputs registered, no backpressure.
// Optional HMS_TIMER_AUTO_RELOAD_EN makes down-counting channels periodic.
module hms_timer_array
  import hms_timer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int HR_W     = 5,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  hms_timer_array_if.slave   bus
);

  localparam int T_W  = HR_W + MIN_W + SEC_W + MS_W;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]       presc_q, presc_d;
  logic                  tick;
  logic [T_W-1:0]        time_v [NUM_CH];
  logic [NUM_CH-1:0]     run_v, done_v, exp_v;
  logic [NUM_CH*T_W-1:0] time_all;

  // Free-running divider; first tick lands PRESCALE edges after reset release.
  assign tick = (presc_q == PS_W'(PRESCALE - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hms_timer_channel #(.HR_W(HR_W)) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .load      (bus.load_valid && (bus.load_ch == 3'(i))),
      .load_time (bus.load_time),
      .load_up   (bus.load_up),
      .start     (bus.start[i]),
      .stop      (bus.stop[i]),
      .time_o    (time_v[i]),
      .running_o (run_v[i]),
      .done_o    (done_v[i]),
      .expired_o (exp_v[i])
    );
  end

  always_comb begin
    time_all = '0;
    for (int i = 0; i < NUM_CH; i++) time_all[i*T_W +: T_W] = time_v[i];
  end

  assign bus.time_o    = time_all;
  assign bus.running_o = run_v;
  assign bus.done_o    = done_v;
  assign bus.expired_o = exp_v;

endmodule

// File: tb/tb_hms_timer_array.sv
// Bench for hms_timer_array: directed table, prescaler/reset sequences, random vs. ms-count model.
module tb_hms_timer_array;
  localparam int MAXT = 115199999;  // 31:59:59.999 in ms
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hms_timer_array_if #(.NUM_CH(4), .HR_W(5)) bus ();
  hms_timer_array_if #(.NUM_CH(2), .HR_W(2)) bus_p ();

  hms_timer_array #(.NUM_CH(4), .HR_W(5), .PRESCALE(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  hms_timer_array #(.NUM_CH(2), .HR_W(2), .PRESCALE(4)) dut_p (
    .clk(clk), .reset_n(reset_n), .bus(bus_p.slave));

  typedef struct {
    logic        lv;
    logic [2:0]  lch;
    logic [26:0] lt;
    logic        lup;
    logic [3:0]  st, sp;
    int          cc;
    logic [26:0] et;
    logic [3:0]  er, ed, ee;
  } vec_t;
  vec_t tbl[19];

  int  m_st[4], m_t[4], m_rel[4];
  bit  m_up[4], m_exp[4];

  function automatic logic [26:0] tw(int h, int m, int s, int ms);
    return {5'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  function automatic logic [26:0] from_ms(int t);
    return tw(t / 3600000, (t / 60000) % 60, (t / 1000) % 60, t % 1000);
  endfunction

  function automatic int to_ms_clamped(logic [26:0] v);
    int h, m, s, ms;
    h = int'(v[26:22]); m = int'(v[21:16]); s = int'(v[15:10]); ms = int'(v[9:0]);
    if (m > 59) m = 59;
    if (s > 59) s = 59;
    if (ms > 999) ms = 999;
    return ((h * 60 + m) * 60 + s) * 1000 + ms;
  endfunction

  function automatic bit at_end(bit up, int t);
    return up ? (t == MAXT) : (t == 0);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [2:0] lch, input logic [26:0] lt,
                       input logic lup, input logic [3:0] st, input logic [3:0] sp);
    bus.load_valid = lv; bus.load_ch = lch; bus.load_time = lt;
    bus.load_up = lup; bus.start = st; bus.stop = sp;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Reference: time held as a plain millisecond count per channel.
  task automatic model_cycle(input logic lv, input logic [2:0] lch, input logic [26:0] lt,
                             input logic lup, input logic [3:0] st, input logic [3:0] sp);
    for (int i = 0; i < 4; i++) begin
      m_exp[i] = 1'b0;
      if (lv && int'(lch) == i) begin
        m_st[i] = M_IDLE; m_t[i] = to_ms_clamped(lt); m_up[i] = lup; m_rel[i] = m_t[i];
      end else if (sp[i]) begin
        if (m_st[i] == M_RUN) m_st[i] = M_PAUSE;
      end else if (st[i] && m_st[i] != M_RUN) begin
        if (!at_end(m_up[i], m_t[i])) m_st[i] = M_RUN;
        else if (m_st[i] != M_DONE) begin m_st[i] = M_DONE; m_exp[i] = 1'b1; end
      end else if (m_st[i] == M_RUN) begin
        m_t[i] = m_up[i] ? m_t[i] + 1 : m_t[i] - 1;
        if (at_end(m_up[i], m_t[i])) begin
          m_exp[i] = 1'b1;
`ifdef HMS_TIMER_AUTO_RELOAD_EN
          if (!m_up[i]) m_t[i] = m_rel[i];
          else m_st[i] = M_DONE;
`else
          m_st[i] = M_DONE;
`endif
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [107:0] et;
    logic [3:0]   er, ed, ee;
    logic         lv, lup;
    logic [2:0]   lch;
    logic [26:0]  lt;
    logic [3:0]   st, sp;
    int           n;
    bit           seen;

    tbl[0]  = '{1'b1, 3'd1, tw(1,0,0,0),     1'b0, 4'b0000, 4'b0000, 1, tw(1,0,0,0),      4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 3'd0, '0,              1'b0, 4'b0010, 4'b0000, 1, tw(1,0,0,0),      4'b0010, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 3'd0, '0,              1'b0, 4'b0000, 4'b0000, 1, tw(0,59,59,999),  4'b0010, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 3'd0, '0,              1'b0, 4'b0010, 4'b0010, 1, tw(0,59,59,999),  4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 3'd0, '0,              1'b0, 4'b0000, 4'b0000, 1, tw(0,59,59,999),  4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b0, 3'd0, '0,              1'b0, 4'b0010, 4'b0000, 1, tw(0,59,59,999),  4'b0010, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b0, 3'd0, '0,              1'b0, 4'b0000, 4'b0000, 1, tw(0,59,59,998),  4'b0010, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b1, 3'd1, tw(0,0,5,0),     1'b1, 4'b0010, 4'b0000, 1, tw(0,0,5,0),      4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b1, 3'd2, tw(2,63,60,1023),1'b0, 4'b0000, 4'b0000, 2, tw(2,59,59,999),  4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b1, 3'd3, tw(0,0,0,0),     1'b0, 4'b0000, 4'b0000, 3, tw(0,0,0,0),      4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 3'd0, '0,              1'b0, 4'b1000, 4'b0000, 3, tw(0,0,0,0),      4'b0000, 4'b1000, 4'b1000};
    tbl[11] = '{1'b0, 3'd0, '0,              1'b0, 4'b0000, 4'b0000, 3, tw(0,0,0,0),      4'b0000, 4'b1000, 4'b0000};
    tbl[12] = '{1'b0, 3'd0, '0,              1'b0, 4'b1000, 4'b0000, 3, tw(0,0,0,0),      4'b0000, 4'b1000, 4'b0000};
    tbl[13] = '{1'b1, 3'd5, tw(7,7,7,7),     1'b0, 4'b0000, 4'b0000, 1, tw(0,0,5,0),      4'b0000, 4'b1000, 4'b0000};
    tbl[14] = '{1'b0, 3'd0, '0,              1'b0, 4'b0000, 4'b0001, 0, tw(0,0,0,0),      4'b0000, 4'b1000, 4'b0000};
    tbl[15] = '{1'b1, 3'd0, tw(31,59,59,998),1'b1, 4'b0000, 4'b0000, 0, tw(31,59,59,998), 4'b0000, 4'b1000, 4'b0000};
    tbl[16] = '{1'b0, 3'd0, '0,              1'b0, 4'b0001, 4'b0000, 0, tw(31,59,59,998), 4'b0001, 4'b1000, 4'b0000};
    tbl[17] = '{1'b0, 3'd0, '0,              1'b0, 4'b0000, 4'b0000, 0, tw(31,59,59,999), 4'b0000, 4'b1001, 4'b0001};
    tbl[18] = '{1'b0, 3'd0, '0,              1'b0, 4'b0000, 4'b0000, 0, tw(31,59,59,999), 4'b0000, 4'b1001, 4'b0000};

    // Reset holds everything at zero even with a load and start requested.
    drive(1'b1, 3'd0, tw(1,2,3,4), 1'b1, 4'b1111, 4'b0000);
    bus_p.load_valid = 1'b0; bus_p.load_ch = '0; bus_p.load_time = '0;
    bus_p.load_up = 1'b0; bus_p.start = '0; bus_p.stop = '0;
    repeat (3) edge1();
    chk("rst_time", bus.time_o, '0);
    chk("rst_run", bus.running_o, '0);
    chk("rst_done", bus.done_o, '0);
    chk("rst_exp", bus.expired_o, '0);
    drive(1'b0, 3'd0, '0, 1'b0, 4'b0000, 4'b0000);

    // Prescaler phase after release: ticks consumed on edges 4, 8, 12, ...
    @(negedge clk);
    reset_n = 1'b1;
    bus_p.load_valid = 1'b1; bus_p.load_ch = 3'd0; bus_p.load_time = {2'd0, 6'd0, 6'd0, 10'd2};
    edge1();
    bus_p.load_valid = 1'b0; bus_p.start = 2'b01;
    edge1();
    chk("pre_start_run", bus_p.running_o[0], 1'b1);
    bus_p.start = 2'b00;
    for (int k = 3; k <= 20; k++) begin
      edge1();
`ifdef HMS_TIMER_AUTO_RELOAD_EN
      chk($sformatf("pre_exp_e%0d", k), bus_p.expired_o[0], (k == 8 || k == 16));
      chk($sformatf("pre_run_e%0d", k), bus_p.running_o[0], 1'b1);
`else
      chk($sformatf("pre_exp_e%0d", k), bus_p.expired_o[0], (k == 8));
      chk($sformatf("pre_run_e%0d", k), bus_p.running_o[0], (k < 8));
`endif
    end

    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].lv, tbl[k].lch, tbl[k].lt, tbl[k].lup, tbl[k].st, tbl[k].sp);
      edge1();
      chk($sformatf("tbl%0d_time", k), bus.time_o[tbl[k].cc*27 +: 27], tbl[k].et);
      chk($sformatf("tbl%0d_run", k), bus.running_o, tbl[k].er);
      chk($sformatf("tbl%0d_done", k), bus.done_o, tbl[k].ed);
      chk($sformatf("tbl%0d_exp", k), bus.expired_o, tbl[k].ee);
    end

    // One-second countdown: expiry lands exactly 1000 edges after start.
    drive(1'b1, 3'd0, tw(0,0,1,0), 1'b0, 4'b0000, 4'b0000);
    edge1();
    drive(1'b0, 3'd0, '0, 1'b0, 4'b0001, 4'b0000);
    edge1();
    drive(1'b0, 3'd0, '0, 1'b0, 4'b0000, 4'b0000);
    n = 0; seen = 1'b0;
    while (!seen && n < 1500) begin
      edge1();
      n++;
      if (bus.expired_o[0] === 1'b1) seen = 1'b1;
    end
    chk("sec_latency", n, 1000);
`ifdef HMS_TIMER_AUTO_RELOAD_EN
    chk("sec_time", bus.time_o[26:0], tw(0,0,1,0));
    chk("sec_done", bus.done_o[0], 1'b0);
    chk("sec_run", bus.running_o[0], 1'b1);
`else
    chk("sec_time", bus.time_o[26:0], tw(0,0,0,0));
    chk("sec_done", bus.done_o[0], 1'b1);
    chk("sec_run", bus.running_o[0], 1'b0);
`endif
    edge1();
    chk("sec_single_pulse", bus.expired_o[0], 1'b0);

    // Asynchronous reset mid-run.
    drive(1'b1, 3'd1, tw(0,5,0,0), 1'b0, 4'b0000, 4'b0000);
    edge1();
    drive(1'b0, 3'd0, '0, 1'b0, 4'b0010, 4'b0000);
    edge1();
    drive(1'b0, 3'd0, '0, 1'b0, 4'b0000, 4'b0000);
    repeat (10) edge1();
    chk("mid_running", bus.running_o[1], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_time", bus.time_o, '0);
    chk("arst_run", bus.running_o, '0);
    chk("arst_done", bus.done_o, '0);
    chk("arst_exp", bus.expired_o, '0);
    chk("arst_time_p", bus_p.time_o, '0);
    repeat (2) begin
      edge1();
      chk("arst_no_exp", bus.expired_o, '0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      m_st[i] = M_IDLE; m_t[i] = 0; m_rel[i] = 0; m_up[i] = 1'b0; m_exp[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      lv = ($urandom % 4 == 0);
      lch = 3'($urandom % 6);
      lup = 1'($urandom);
      case ($urandom % 4)
        0: lt = 27'($urandom);
        1: begin lt = from_ms(int'($urandom % 30)); lup = 1'b0; end
        2: begin lt = from_ms(MAXT - int'($urandom % 30)); lup = 1'b1; end
        default: lt = tw(int'($urandom % 3), int'($urandom % 64), int'($urandom % 64), int'($urandom % 1024));
      endcase
      for (int b = 0; b < 4; b++) begin
        st[b] = ($urandom % 3 == 0);
        sp[b] = ($urandom % 8 == 0);
      end
      drive(lv, lch, lt, lup, st, sp);
      model_cycle(lv, lch, lt, lup, st, sp);
      edge1();
      for (int i = 0; i < 4; i++) begin
        et[i*27 +: 27] = from_ms(m_t[i]);
        er[i] = (m_st[i] == M_RUN);
        ed[i] = (m_st[i] == M_DONE);
        ee[i] = m_exp[i];
      end
      chk($sformatf("rnd%0d_time", cyc), bus.time_o, et);
      chk($sformatf("rnd%0d_run", cyc), bus.running_o, er);
      chk($sformatf("rnd%0d_done", cyc), bus.done_o, ed);
      chk($sformatf("rnd%0d_exp", cyc), bus.expired_o, ee);
    end
    drive(1'b0, 3'd0, '0, 1'b0, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hms_timer_array.md
HMS_TIMER_ARRAY -- requirements
Module: hms_timer_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: independent timer channels, legal range 1..8.
REQ-002 SHALL have parameter HR_W, default 5: hour field width, legal range 1..8.
REQ-003 SHALL have parameter PRESCALE, default 1: clk cycles per millisecond tick, legal range 1..2^20.
REQ-004 SHALL define T_W = HR_W+22 as the time word {hr[HR_W-1:0], min[5:0], sec[5:0], ms[9:0]}, MSB first.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port load_valid, input, 1: load request for one channel this cycle.
REQ-008 SHALL have port load_ch, input, 3: target channel index; values >= NUM_CH are ignored.
REQ-009 SHALL have port load_time, input, T_W: preset value.
REQ-010 SHALL have port load_up, input, 1: counting mode (1 = count up/stopwatch, 0 = count down).
REQ-011 SHALL have port start, input, NUM_CH: per-channel run request.
REQ-012 SHALL have port stop, input, NUM_CH: per-channel pause request.
REQ-013 SHALL have port time_o, output, NUM_CH*T_W: current time; channel i in bits [i*T_W +: T_W].
REQ-014 SHALL have port running_o, output, NUM_CH: channel is in RUN.
REQ-015 SHALL have port done_o, output, NUM_CH: channel is in DONE (level).
REQ-016 SHALL have port expired_o, output, NUM_CH: single-cycle pulse when a channel reaches its terminal value.

Function
REQ-017 SHALL generate one tick every PRESCALE clk cycles from a free-running prescaler shared by all channels; with PRESCALE=1, tick is high every cycle.
REQ-018 SHALL give each channel the states IDLE, RUN, PAUSE, DONE.
- IDLE -start-> RUN; RUN -stop-> PAUSE; PAUSE -start-> RUN; RUN -terminal-> DONE.
- DONE -start-> RUN, only when the time is not already terminal.
REQ-019 SHALL apply per-channel priority load > stop > start; load forces IDLE with the new time and mode on the next edge.
REQ-020 SHALL clamp loaded fields to legal range: ms>999 becomes 999; sec>59 and min>59 become 59.
REQ-021 SHALL advance a channel by 1 ms only on a tick while in RUN; advancing is a single-cycle update.
REQ-022 In down mode, SHALL borrow cascade: ms 0->999 with sec-1; sec 0->59 with min-1; min 0->59 with hr-1.
REQ-023 In down mode, SHALL treat all-zero as terminal; the channel holds at zero.
REQ-024 In up mode, SHALL carry cascade: ms 999->0 with sec+1; sec 59->0 with min+1; min 59->0 with hr+1.
REQ-025 In up mode, SHALL treat {hr all-ones, 59, 59, 999} as terminal; the channel saturates and holds.
REQ-026 On the terminal edge, SHALL pulse expired_o for exactly one clk and enter DONE in the same edge.
REQ-027 SHALL leave state unchanged when start is asserted in RUN or stop is asserted outside RUN.
REQ-028 SHALL allow simultaneous load, start and stop on different channels, each resolved independently.
REQ-029 SHALL place a channel loaded with a terminal value in IDLE; a subsequent start sends it straight to DONE with an expired_o pulse.

Reset
REQ-030 While reset_n=0, SHALL hold all channels in IDLE in down mode with time 0, the prescaler at 0, and every output bit 0.
REQ-031 SHALL abandon any run in progress when reset is asserted mid-operation; first tick after reset_n rises occurs PRESCALE cycles later.

Configuration
REQ-032 SHALL support macro HMS_TIMER_AUTO_RELOAD_EN.
- Defined: in down mode, on reaching zero the channel pulses expired_o, reloads its last loaded value, and stays in RUN (periodic); up mode is unaffected.
- Undefined: the channel enters DONE as in REQ-026.

Structure
REQ-033 SHALL place in shared package hms_timer_pkg: the channel state enum, field widths for ms/sec/min (10/6/6), and constants MS_MAX=999 and SEC_MIN_MAX=59.
REQ-034 SHALL implement one channel (state, time, mode, reload register) as sub-module hms_timer_channel, instantiated NUM_CH times by a generate loop.

Verification
REQ-035 PRESCALE=1: load ch0 = 0:00:01.000 down, start -> after 1000 clk, time=0, expired_o[0] pulses once, done_o[0]=1.
REQ-036 Borrow: load 1:00:00.000 down, run 1 tick -> 0:59:59.999.
REQ-037 Up saturation with HR_W=5: load 31:59:59.998 up, run 2 ticks -> holds at 31:59:59.999, one expired_o pulse.
REQ-038 Pause/priority: run ch1, assert stop+start together -> PAUSE and time frozen; load+start together -> IDLE with the loaded value.
REQ-039 Clamp: load {2,63,60,1023} -> time_o reads 2:59:59.999.
REQ-040 With HMS_TIMER_AUTO_RELOAD_EN and PRESCALE=4: load 0:00:00.002 down, start -> expired_o pulses every 8 clk and running_o stays 1.
REQ-041 reset_n pulled low mid-run -> all outputs 0 asynchronously, with no expired_o pulse.
